// File: rtl/affine_interp_pkg.sv
// Shared constants for the affine-interpolation tap-4 multiplier-by-constant datapath.
package affine_interp_pkg;

   localparam logic [1:0] PH_ZERO = 2'd0;
   localparam logic [1:0] PH_M4   = 2'd1;
   localparam logic [1:0] PH_M10  = 2'd2;
   localparam logic [1:0] PH_M11  = 2'd3;

   // Coefficient selected by each phase code, for reference models.
   localparam int COEFF_TAB [4] = '{0, -4, -10, -11};

   // Lossless product width for a DATA_W-bit signed sample times |coeff| <= 11.
   function automatic int unsigned prod_w(input int unsigned data_w);
      return data_w + 32'd4;
   endfunction

endpackage

// File: rtl/affine_t4_mcm_lane.sv
// One lane of the tap-4 MCM: stage-1 shared shift-add terms, stage-2 select/negate/reduce.
// AFFINE_T4_MCM_SAT_EN selects clamping (and a per-lane clamp indication) instead of wrapping.
module affine_t4_mcm_lane
   import affine_interp_pkg::*;
#(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned OUT_W  = DATA_W + 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en1,
   input  logic                     en2,
   input  logic signed [DATA_W-1:0] x,
   input  logic [1:0]               phase,
   output logic signed [OUT_W-1:0]  y
`ifdef AFFINE_T4_MCM_SAT_EN
   ,
   output logic                     sat_c
`endif
);

   localparam int unsigned EW = DATA_W + 5;

   logic signed [EW-1:0] w1, w4, w5, w16;
   logic signed [EW-1:0] w4_q, w5_q, w16_q;
   logic [1:0]           ph_q;
   logic signed [EW-1:0] w11, prod;
   logic signed [OUT_W-1:0] y_n;

   // Shared terms: w4 = 4x, w5 = 5x, w16 = 16x, all sign-extended to EW bits.
   always_comb begin
      w1  = EW'(x);
      w4  = w1 <<< 2;
      w5  = w1 + w4;
      w16 = w1 <<< 4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w4_q  <= '0;
         w5_q  <= '0;
         w16_q <= '0;
         ph_q  <= PH_ZERO;
      end else if (en1) begin
         w4_q  <= w4;
         w5_q  <= w5;
         w16_q <= w16;
         ph_q  <= phase;
      end
   end

   always_comb begin
      w11  = w16_q - w5_q;
      prod = '0;
      case (ph_q)
         PH_ZERO: prod = '0;
         PH_M4:   prod = -w4_q;
         PH_M10:  prod = -(w5_q <<< 1);
         PH_M11:  prod = -w11;
         default: prod = '0;
      endcase
   end

`ifdef AFFINE_T4_MCM_SAT_EN
   localparam bit CLAMP = (OUT_W < DATA_W + 4);
   localparam logic signed [EW-1:0] SAT_MAX = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [EW-1:0] SAT_MIN = EW'(-(64'sd1 <<< (OUT_W - 1)));

   // Clamp only when the output is narrower than the lossless product width.
   always_comb begin
      sat_c = 1'b0;
      y_n   = OUT_W'(prod);
      if (CLAMP) begin
         if (prod > SAT_MAX) begin
            y_n   = OUT_W'(SAT_MAX);
            sat_c = 1'b1;
         end else if (prod < SAT_MIN) begin
            y_n   = OUT_W'(SAT_MIN);
            sat_c = 1'b1;
         end
      end
   end
`else
   always_comb y_n = OUT_W'(prod);
`endif

   always_ff @(posedge clk) begin
      if (rst)
         y <= '0;
      else if (en2)
         y <= y_n;
   end

endmodule

// File: rtl/affine_t4_mcm_pipe.sv
// Two-stage valid/ready pipelined tap-4 MCM over LANES independent signed samples.
// AFFINE_T4_MCM_SAT_EN enables per-lane clamping and the sat_flag output.
module affine_t4_mcm_pipe
   import affine_interp_pkg::*;
#(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned LANES  = 4,
   parameter int unsigned OUT_W  = prod_w(DATA_W)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*DATA_W-1:0]  in_data,
   input  logic [LANES*2-1:0]       in_phase,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   out_data
`ifdef AFFINE_T4_MCM_SAT_EN
   ,
   output logic                     sat_flag
`endif
);

   logic v1, v2;
   logic adv2, acc, ld2;

   // Stage 2 advances when empty or draining; stage 1 when empty or stage 2 advances.
   always_comb begin
      adv2     = !v2 || out_ready;
      in_ready = !rst && (!v1 || adv2);
      acc      = in_valid && in_ready;
      ld2      = adv2 && v1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         if (!v1 || adv2)
            v1 <= acc;
         if (adv2)
            v2 <= v1;
      end
   end

   assign out_valid = v2;

`ifdef AFFINE_T4_MCM_SAT_EN
   logic [LANES-1:0] lane_sat;

   always_ff @(posedge clk) begin
      if (rst)
         sat_flag <= 1'b0;
      else if (ld2)
         sat_flag <= |lane_sat;
   end
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      affine_t4_mcm_lane #(
         .DATA_W (DATA_W),
         .OUT_W  (OUT_W)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .en1   (acc),
         .en2   (ld2),
         .x     (in_data[l*DATA_W +: DATA_W]),
         .phase (in_phase[2*l +: 2]),
         .y     (out_data[l*OUT_W +: OUT_W])
`ifdef AFFINE_T4_MCM_SAT_EN
         ,
         .sat_c (lane_sat[l])
`endif
      );
   end

endmodule

// File: tb/tb_affine_t4_mcm_pipe.sv
// Bench for affine_t4_mcm_pipe: directed and random beats checked against a queue-based model.
module tb_affine_t4_mcm_pipe;

   localparam int unsigned DW = 10;
   localparam int unsigned LN = 4;
   localparam int unsigned OW = 14;
   localparam int unsigned OW12 = 12;

   logic clk = 1'b0;
   logic rst, in_valid, out_ready;
   logic [LN*DW-1:0] in_data;
   logic [LN*2-1:0]  in_phase;
   logic in_ready, out_valid, in_ready12, out_valid12;
   logic [LN*OW-1:0]   out_data;
   logic [LN*OW12-1:0] out_data12;
`ifdef AFFINE_T4_MCM_SAT_EN
   logic sat_flag, sat_flag12;
`endif

   always #5 clk = ~clk;

   affine_t4_mcm_pipe #(.DATA_W(DW), .LANES(LN), .OUT_W(OW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_phase(in_phase), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
`ifdef AFFINE_T4_MCM_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   affine_t4_mcm_pipe #(.DATA_W(DW), .LANES(LN), .OUT_W(OW12)) u_dut12 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
      .in_data(in_data), .in_phase(in_phase), .out_valid(out_valid12),
      .out_ready(out_ready), .out_data(out_data12)
`ifdef AFFINE_T4_MCM_SAT_EN
      , .sat_flag(sat_flag12)
`endif
   );

   typedef struct {
      logic [LN*OW-1:0]   d;
      logic [LN*OW12-1:0] d12;
      logic               sat;
      bit                 s2;
   } ent_t;

   ent_t q[$];
   int   coef[4] = '{0, -4, -10, -11};
   int   n_assert = 0;
   int   n_fail = 0;
   bit   accepted;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LN*DW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
      return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
   endfunction

   // Expected products of the current input beat for both output widths.
   function automatic ent_t make_ent();
      ent_t e;
      logic signed [DW-1:0] xs;
      int v, c;
      e.d = '0; e.d12 = '0; e.sat = 1'b0; e.s2 = 1'b0;
      for (int l = 0; l < LN; l++) begin
         xs = in_data[l*DW +: DW];
         v  = int'(xs) * coef[in_phase[2*l +: 2]];
         e.d[l*OW +: OW] = OW'(v);
`ifdef AFFINE_T4_MCM_SAT_EN
         c = v;
         if (v > 2047) begin c = 2047; e.sat = 1'b1; end
         if (v < -2048) begin c = -2048; e.sat = 1'b1; end
`else
         c = v;
`endif
         e.d12[l*OW12 +: OW12] = OW12'(c);
      end
      return e;
   endfunction

   // One clock: check outputs mid-cycle, then advance the model across the edge.
   task automatic step();
      bit exp_ov, exp_ir, drn;
      ent_t e, h;
      #1;
      exp_ov = (q.size() > 0) && q[0].s2;
      exp_ir = !rst && ((q.size() < 2) || (exp_ov && out_ready));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) begin
         chk("out_data", 64'(out_data), 64'(q[0].d));
         chk("out_data12", 64'(out_data12), 64'(q[0].d12));
`ifdef AFFINE_T4_MCM_SAT_EN
         chk("sat_flag", 64'(sat_flag), 64'(0));
         chk("sat_flag12", 64'(sat_flag12), 64'(q[0].sat));
`endif
      end
      accepted = in_valid && exp_ir;
      drn = exp_ov && out_ready;
      e = make_ent();
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (q.size() > 0 && !q[0].s2) begin
            h = q[0]; h.s2 = 1'b1; q[0] = h;
         end
         if (accepted) q.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int beat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_phase = '0;
      @(negedge clk);
      step(); step();
      rst = 1'b0;
      chk("reset_data", 64'(out_data), 64'(0));
`ifdef AFFINE_T4_MCM_SAT_EN
      chk("reset_sat", 64'(sat_flag12), 64'(0));
`endif

      // Basic products: 100 on every lane, phases 0..3.
      in_valid = 1'b1; in_data = pack4(100, 100, 100, 100); in_phase = 8'b11_10_01_00;
      step();
      in_valid = 1'b0;
      repeat (3) step();

      // Extremes with phase 2, then -512 with phase 3.
      in_valid = 1'b1; in_data = pack4(-512, 511, -1, 1); in_phase = 8'hAA;
      step();
      in_data = pack4(-512, -512, -512, -512); in_phase = 8'hFF;
      step();
      // Narrow-output wrap/clamp cases.
      in_data = pack4(511, 511, 511, 511);
      step();
      in_data = pack4(100, 100, 100, 100);
      step();
      in_valid = 1'b0;
      repeat (3) step();

      // Back-pressure: ramp 1..5 at phase 1, out_ready low during cycles 3-6.
      beat = 1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (beat <= 5);
         in_data = pack4(beat, beat, beat, beat);
         in_phase = 8'h55;
         out_ready = !(c >= 3 && c <= 6);
         step();
         if (accepted) beat++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) step();

      // Reset with both stages full.
      out_ready = 1'b0; in_valid = 1'b1; in_data = pack4(3, 4, 5, 6); in_phase = 8'hE4;
      repeat (3) step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0; out_ready = 1'b1;
      chk("midrst_data", 64'(out_data), 64'(0));
      in_valid = 1'b1; in_data = pack4(7, 7, 7, 7); in_phase = 8'hFF;
      step();
      in_valid = 1'b0;
      repeat (3) step();

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = LN*DW'($urandom()) ^ (LN*DW'($urandom()) << 20);
         in_phase  = 8'($urandom());
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
